// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter.
// Sends a WIDTH-bit word LSB-first as: start(0), data, optional even parity, stop(1).
// Each bit is held for CLKS_PER_BIT cycles. The tx line is registered and idles high.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | line high, ready for a new word
// S_START  | start bit (0) on the line
// S_DATA   | data bits, LSB first, shifted out of shift_reg
// S_PARITY | even-parity bit (XOR of the captured word)
// S_STOP   | stop bit (1); done pulses on the first IDLE cycle after it
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             parity_bit;
    logic             cyc_last;
    logic             tx_next;
    logic             done_next;

    assign cyc_last = (cyc_cnt == CYC_LAST);
    assign busy     = (state != S_IDLE);
    assign ready    = ~busy;

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: every non-idle state advances on the last cycle of its bit.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (load) state_next = S_START;
            S_START:  if (cyc_last) state_next = S_DATA;
            S_DATA: begin
                if (cyc_last && (bit_cnt == BIT_LAST)) begin
                    state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (cyc_last) state_next = S_STOP;
            S_STOP:   if (cyc_last) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode: tx is computed from the next state so the registered line
    // changes on the same edge as the state (start bit falls on the load edge).
    always_comb begin
        shift_next = shift_reg;
        if ((state == S_DATA) && cyc_last) begin
            shift_next = shift_reg >> 1;
        end
        tx_next = 1'b1;
        unique case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_bit;
            default:  tx_next = 1'b1;
        endcase
        done_next = (state == S_STOP) && cyc_last;
    end

    // Datapath: word capture, bit/cycle counters, registered tx and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx         <= 1'b1;
            done       <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
        end else begin
            tx   <= tx_next;
            done <= done_next;
            if (state == S_IDLE) begin
                cyc_cnt <= '0;
                bit_cnt <= '0;
                if (load) begin
                    shift_reg  <= data_in;
                    parity_bit <= ^data_in;
                end
            end else begin
                cyc_cnt   <= cyc_last ? '0 : cyc_cnt + CW'(1);
                shift_reg <= shift_next;
                if ((state == S_DATA) && cyc_last) begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed testbench for serial_frame_tx: default build (8 bits, 4 clocks/bit,
// parity) plus a fast build (1 clock/bit, no parity) on the same clock and reset.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load = 1'b0;
    logic       ready, tx, busy, done;
    logic [7:0] data1 = 8'h00;
    logic       load1 = 1'b0;
    logic       ready1, tx1, busy1, done1;

    int n_pass = 0;
    int n_total = 0;

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready), .tx(tx), .busy(busy), .done(done)
    );

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_fast (
        .clk(clk), .reset(reset), .data_in(data1), .load(load1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame on the default build and checks every cycle of it.
    // keep_load leaves load high with nxt on data_in for a back-to-back frame;
    // poke_busy pulses load with 0xFF during data bit 3; abort resets during data bit 5.
    task automatic run_frame(input logic [7:0] d, input string name, input bit keep_load,
                             input logic [7:0] nxt, input bit poke_busy, input bit abort);
        logic [10:0] exp;
        logic [7:0]  rx;
        bit          stop;
        exp = {1'b1, ^d, d, 1'b0};
        rx = 8'h00;
        stop = 1'b0;
        data_in = d;
        load = 1'b1;
        step();
        if (keep_load) data_in = nxt;
        else begin
            load = 1'b0;
            data_in = ~d;
        end
        for (int b = 0; b < 11 && !stop; b++) begin
            for (int c = 0; c < 4 && !stop; c++) begin
                n_total++;
                if (tx !== exp[b] || busy !== 1'b1 || done !== 1'b0)
                    $display("FAIL %s bit%0d cyc%0d: got tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                             name, b, c, tx, busy, done, exp[b]);
                else n_pass++;
                if (c == 2 && b >= 1 && b <= 8) rx[b-1] = tx;
                if (poke_busy && b == 4 && c == 1) begin
                    load = 1'b1;
                    data_in = 8'hFF;
                end
                if (poke_busy && b == 4 && c == 2) begin
                    load = 1'b0;
                    data_in = ~d;
                end
                if (abort && b == 6 && c == 1) begin
                    reset = 1'b0;
                    stop = 1'b1;
                end
                step();
            end
        end
        if (abort) begin
            n_total++;
            if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0)
                $display("FAIL %s abort: got tx=%b busy=%b ready=%b done=%b, want 1 0 1 0",
                         name, tx, busy, ready, done);
            else n_pass++;
            reset = 1'b1;
            begin
                bit bad;
                bad = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    step();
                    if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
                end
                n_total++;
                if (bad) $display("FAIL %s post_abort: got activity after reset, want quiet idle", name);
                else n_pass++;
            end
        end else begin
            n_total++;
            if (done !== 1'b1 || ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0)
                $display("FAIL %s end: got done=%b ready=%b tx=%b busy=%b, want 1 1 1 0",
                         name, done, ready, tx, busy);
            else n_pass++;
            n_total++;
            if (rx !== d) $display("FAIL %s rx: got %h, want %h", name, rx, d);
            else n_pass++;
            if (!keep_load) begin
                step();
                n_total++;
                if (done !== 1'b0 || tx !== 1'b1)
                    $display("FAIL %s done_width: got done=%b tx=%b, want 0 1", name, done, tx);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        bit bad;
        load = 1'b1;
        data_in = 8'h00;
        reset = 1'b0;
        step();
        step();
        n_total++;
        if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0)
            $display("FAIL reset_state: got tx=%b busy=%b ready=%b done=%b, want 1 0 1 0",
                     tx, busy, ready, done);
        else n_pass++;
        n_total++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL reset_fast: got tx=%b busy=%b done=%b, want 1 0 0", tx1, busy1, done1);
        else n_pass++;
        load = 1'b0;
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL idle_quiet: got line activity while idle, want tx=1 busy=0");
        else n_pass++;
    endtask

    task automatic test_single_frame();
        run_frame(8'hA5, "frame_a5", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_parity();
        run_frame(8'h01, "parity_01", 1'b0, 8'h00, 1'b0, 1'b0);
        run_frame(8'h00, "parity_00", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(8'h3C, "b2b_first", 1'b1, 8'hC3, 1'b0, 1'b0);
        run_frame(8'hC3, "b2b_second", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_load_while_busy();
        bit bad;
        run_frame(8'h12, "busy_load", 1'b0, 8'h00, 1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL busy_not_queued: got a frame after ignored load, want idle");
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        run_frame(8'h6B, "abort", 1'b0, 8'h00, 1'b0, 1'b1);
        run_frame(8'h5A, "after_abort", 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_fast_build();
        logic [9:0] exp;
        exp = {1'b1, 8'h80, 1'b0};
        data1 = 8'h80;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        data1 = 8'h00;
        for (int b = 0; b < 10; b++) begin
            n_total++;
            if (tx1 !== exp[b] || busy1 !== 1'b1 || done1 !== 1'b0)
                $display("FAIL fast bit%0d: got tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                         b, tx1, busy1, done1, exp[b]);
            else n_pass++;
            step();
        end
        n_total++;
        if (done1 !== 1'b1 || ready1 !== 1'b1 || tx1 !== 1'b1)
            $display("FAIL fast_end: got done=%b ready=%b tx=%b, want 1 1 1", done1, ready1, tx1);
        else n_pass++;
        step();
        n_total++;
        if (done1 !== 1'b0) $display("FAIL fast_done_width: got done=%b, want 0", done1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_frame();
        test_fast_build();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
